// File: rtl/otter_intr_pkg.sv
// Shared definitions for the interrupt controller.
//   state_e            : controller FSM states (IDLE, REQ, SERVICE)
//   NUM_SRC_DEFAULT    : default number of interrupt sources
//   prio_enc()         : lowest-index-wins priority encoder over up to 8 sources
package otter_intr_pkg;

    localparam int unsigned NUM_SRC_DEFAULT = 4;
    localparam int unsigned MAX_SRC         = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Returns the index of the lowest set bit; 0 when the vector is empty
    // (callers only use the result when the vector is nonzero).
    function automatic logic [2:0] prio_enc(input logic [MAX_SRC-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_sync.sv
// Two-flop synchronizer for asynchronous interrupt lines.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both stages
//   d_i   : asynchronous input bits
//   q_o   : synchronized output bits (two cycles of latency)
module intr_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: rising-edge capture into a pending register, masked
// lowest-index-first arbitration, and an IDLE/REQ/SERVICE handshake with the
// MCU FSM (no nesting).
//   CLK, RST     : clock, asynchronous active-high reset
//   IRQ          : raw interrupt lines (rising edge fires)
//   IRQ_MASK     : per-source enable
//   CSR_MSTATUS  : global interrupt enable (MIE)
//   INT_ACK      : trap-entry pulse from the MCU FSM
//   CSR_MRET     : MRET pulse, ends service
//   PEND_CLR     : software clear of pending bits
//   INT_REQ      : registered interrupt request
//   INT_ID       : index of the requested / in-service source
//   PENDING      : raw pending register
// Build option: define INTR_SYNC_EN to put a 2-flop synchronizer on IRQ.
module intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic [NUM_SRC-1:0] IRQ_MASK,
    input  logic               CSR_MSTATUS,
    input  logic               INT_ACK,
    input  logic               CSR_MRET,
    input  logic [NUM_SRC-1:0] PEND_CLR,
    output logic               INT_REQ,
    output logic [ID_W-1:0]    INT_ID,
    output logic [NUM_SRC-1:0] PENDING
);

    state_e             state_q, state_d;
    logic               int_req_q, int_req_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] irq_d_q;
    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] id_sel;
    logic [MAX_SRC-1:0] elig_wide;
    logic [ID_W-1:0]    win_idx;
    logic               ack_hit;

`ifdef INTR_SYNC_EN
    intr_sync #(
        .WIDTH(NUM_SRC)
    ) u_intr_sync (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  (IRQ),
        .q_o  (irq_s)
    );
`else
    assign irq_s = IRQ;
`endif

    assign rise     = irq_s & ~irq_d_q;
    assign eligible = pending_q & IRQ_MASK;

    always_comb begin
        elig_wide                = '0;
        elig_wide[NUM_SRC-1:0]   = eligible;
        win_idx                  = ID_W'(prio_enc(elig_wide));
        id_sel                   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_sel[i] = (int_id_q == ID_W'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        ack_hit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CSR_MSTATUS && (|eligible)) begin
                    state_d  = REQ;
                    int_id_d = win_idx;
                end
            end
            REQ: begin
                // Acknowledge wins over a simultaneous withdrawal.
                if (INT_ACK) begin
                    state_d = SERVICE;
                    ack_hit = 1'b1;
                end else if (!CSR_MSTATUS || !(|(eligible & id_sel))) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (CSR_MRET) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // New edges are OR'd in last so a set beats a same-cycle clear.
        pending_d = (pending_q & ~(PEND_CLR | (ack_hit ? id_sel : '0))) | rise;
        int_req_d = (state_d == REQ);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
            pending_q <= '0;
            irq_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            int_req_q <= int_req_d;
            int_id_q  <= int_id_d;
            pending_q <= pending_d;
            irq_d_q   <= irq_s;
        end
    end

    assign INT_REQ = int_req_q;
    assign INT_ID  = int_id_q;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl (NUM_SRC=4). Expectations are queued when
// stimulus is applied and compared once the clock edge has taken effect.
module tb_intr_ctrl;

`ifdef INTR_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] IRQ;
    logic [3:0] IRQ_MASK;
    logic       CSR_MSTATUS;
    logic       INT_ACK;
    logic       CSR_MRET;
    logic [3:0] PEND_CLR;
    logic       INT_REQ;
    logic [1:0] INT_ID;
    logic [3:0] PENDING;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic       req;
        logic [1:0] id;
        logic [3:0] pend;
    } exp_t;

    exp_t sb[$];

    intr_ctrl #(
        .NUM_SRC(4),
        .ID_W   (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IRQ        (IRQ),
        .IRQ_MASK   (IRQ_MASK),
        .CSR_MSTATUS(CSR_MSTATUS),
        .INT_ACK    (INT_ACK),
        .CSR_MRET   (CSR_MRET),
        .PEND_CLR   (PEND_CLR),
        .INT_REQ    (INT_REQ),
        .INT_ID     (INT_ID),
        .PENDING    (PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic r, input logic [1:0] i,
                              input logic [3:0] p);
        exp_t e;
        e.tag  = tag;
        e.req  = r;
        e.id   = i;
        e.pend = p;
        sb.push_back(e);
    endtask

    task automatic compare_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (INT_REQ === e.req) else begin
                failures++;
                $error("FAIL %s int_req observed=%0b expected=%0b", e.tag, INT_REQ, e.req);
            end
            checks++;
            assert (INT_ID === e.id) else begin
                failures++;
                $error("FAIL %s int_id observed=%0d expected=%0d", e.tag, INT_ID, e.id);
            end
            checks++;
            assert (PENDING === e.pend) else begin
                failures++;
                $error("FAIL %s pending observed=%b expected=%b", e.tag, PENDING, e.pend);
            end
        end
    endtask

    // Queue the expectation, advance one edge, then compare.
    task automatic step(input string tag, input logic r, input logic [1:0] i,
                        input logic [3:0] p);
        expect_out(tag, r, i, p);
        tick();
        compare_all();
    endtask

    initial begin
        RST         = 1'b1;
        IRQ         = 4'b0000;
        IRQ_MASK    = 4'hF;
        CSR_MSTATUS = 1'b1;
        INT_ACK     = 1'b0;
        CSR_MRET    = 1'b0;
        PEND_CLR    = 4'b0000;

        #3;
        expect_out("reset", 1'b0, 2'd0, 4'b0000);
        compare_all();
        tick();
        RST = 1'b0;
        step("post_reset", 1'b0, 2'd0, 4'b0000);

        // Single source 2: pending one edge after the rise, request one edge later.
        IRQ = 4'b0100;
        repeat (SYNC_LAT) tick();
        step("irq2_pend", 1'b0, 2'd0, 4'b0100);
        step("irq2_req", 1'b1, 2'd2, 4'b0100);
        INT_ACK = 1'b1;
        step("irq2_ack", 1'b0, 2'd2, 4'b0000);
        INT_ACK = 1'b0;
        IRQ = 4'b0000;
        CSR_MRET = 1'b1;
        step("irq2_mret", 1'b0, 2'd2, 4'b0000);
        CSR_MRET = 1'b0;

        // Sources 3 and 1 together: 1 wins, 3 follows after MRET.
        IRQ = 4'b1010;
        repeat (SYNC_LAT) tick();
        step("dual_pend", 1'b0, 2'd2, 4'b1010);
        step("dual_req1", 1'b1, 2'd1, 4'b1010);
        INT_ACK = 1'b1;
        step("dual_ack1", 1'b0, 2'd1, 4'b1000);
        INT_ACK = 1'b0;
        IRQ = 4'b0000;
        step("svc_hold", 1'b0, 2'd1, 4'b1000);
        INT_ACK = 1'b1;
        step("svc_ack_ignored", 1'b0, 2'd1, 4'b1000);
        INT_ACK = 1'b0;
        CSR_MRET = 1'b1;
        step("dual_mret", 1'b0, 2'd1, 4'b1000);
        CSR_MRET = 1'b0;
        step("dual_req3", 1'b1, 2'd3, 4'b1000);

        // MIE drops while requesting: withdraw, keep pending.
        CSR_MSTATUS = 1'b0;
        step("mie_drop", 1'b0, 2'd3, 4'b1000);
        step("mie_off_idle", 1'b0, 2'd3, 4'b1000);
        PEND_CLR = 4'b1000;
        step("sw_clear", 1'b0, 2'd3, 4'b0000);
        PEND_CLR = 4'b0000;
        CSR_MSTATUS = 1'b1;

        // Latched source masked off while requesting: withdraw.
        IRQ = 4'b0010;
        repeat (SYNC_LAT) tick();
        step("mask_pend", 1'b0, 2'd3, 4'b0010);
        step("mask_req1", 1'b1, 2'd1, 4'b0010);
        IRQ_MASK = 4'b1101;
        step("mask_withdraw", 1'b0, 2'd1, 4'b0010);
        PEND_CLR = 4'b0010;
        step("mask_clear", 1'b0, 2'd1, 4'b0000);
        PEND_CLR = 4'b0000;
        IRQ_MASK = 4'hF;
        IRQ = 4'b0000;
        repeat (1 + SYNC_LAT) tick();

        // Source 0 re-fires in its own ACK cycle: set beats ack-clear.
        IRQ = 4'b0001;
        repeat (SYNC_LAT) tick();
        step("src0_pend", 1'b0, 2'd1, 4'b0001);
        step("src0_req", 1'b1, 2'd0, 4'b0001);
        IRQ = 4'b0000;
        repeat (1 + SYNC_LAT) tick();
        IRQ = 4'b0001;
        repeat (SYNC_LAT) tick();
        INT_ACK = 1'b1;
        step("set_wins", 1'b0, 2'd0, 4'b0001);
        INT_ACK = 1'b0;
        CSR_MRET = 1'b1;
        step("src0_mret", 1'b0, 2'd0, 4'b0001);
        CSR_MRET = 1'b0;
        step("src0_rereq", 1'b1, 2'd0, 4'b0001);
        INT_ACK = 1'b1;
        step("src0_ack2", 1'b0, 2'd0, 4'b0000);
        INT_ACK = 1'b0;
        IRQ = 4'b0000;
        CSR_MRET = 1'b1;
        step("src0_mret2", 1'b0, 2'd0, 4'b0000);
        CSR_MRET = 1'b0;

        // Asynchronous reset in the middle of service.
        IRQ = 4'b1100;
        repeat (SYNC_LAT) tick();
        step("rst_pend", 1'b0, 2'd0, 4'b1100);
        step("rst_req2", 1'b1, 2'd2, 4'b1100);
        INT_ACK = 1'b1;
        step("rst_svc", 1'b0, 2'd2, 4'b1000);
        INT_ACK = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        expect_out("async_reset", 1'b0, 2'd0, 4'b0000);
        compare_all();
        IRQ = 4'b0000;
        step("reset_held", 1'b0, 2'd0, 4'b0000);
        RST = 1'b0;
        step("reset_released", 1'b0, 2'd0, 4'b0000);

        // Masked source still records pending but never requests.
        IRQ_MASK = 4'b1011;
        IRQ = 4'b0100;
        repeat (SYNC_LAT) tick();
        step("masked_pend", 1'b0, 2'd0, 4'b0100);
        step("masked_noreq1", 1'b0, 2'd0, 4'b0100);
        step("masked_noreq2", 1'b0, 2'd0, 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
